// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO ingress arbiter and the egress schedulers
// that reuse its round-robin picker.
//   arb_state_e   : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   DEF_*         : default data width, requester count and burst limit
//   next_rr()     : round-robin pointer advance with explicit wrap, so it is
//                   correct for requester counts that are not a power of two
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_WIDTH     = 72;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 16;

    // Pointer to the requester after ptr, wrapping at n.
    function automatic int next_rr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Purely combinational round-robin winner selection. Searches the request
// vector starting at ptr and moving upward with wrap; the first set bit wins.
// Ports:
//   req       in  NUM_REQ  request vector (one bit per requester)
//   ptr       in  LOG_REQ  highest-priority index for this pick
//   winner    out LOG_REQ  selected index (0 when nothing requests)
//   any_valid out 1        at least one request bit is set
// ---------------------------------------------------------------------------
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LOG_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LOG_REQ-1:0] ptr,
    output logic [LOG_REQ-1:0] winner,
    output logic               any_valid
);

    logic               hi_found;
    logic [LOG_REQ-1:0] hi_idx;
    logic               lo_found;
    logic [LOG_REQ-1:0] lo_idx;

    // Two-level search instead of a modulo walk: the lowest requester at or
    // above ptr wins; if none exists the search has wrapped, so the lowest
    // requester overall wins. Scanning downward leaves the lowest match last.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = LOG_REQ'(i);
                if (LOG_REQ'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = LOG_REQ'(i);
                end
            end
        end
        winner    = hi_found ? hi_idx : lo_idx;
        any_valid = lo_found;
    end

endmodule

// File: rtl/fifo_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_ingress_arbiter
// Round-robin arbiter sharing one streaming FIFO write port among NUM_REQ
// producers. A grant covers a whole burst: it is held until the producer
// marks s_last or MAX_BURST beats have moved. One IDLE bubble cycle separates
// bursts; while granted, the chosen producer is passed straight through.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   s_data        in  NUM_REQ*WIDTH  producer data, requester i at [i*WIDTH +: WIDTH]
//   s_valid       in  NUM_REQ        producer valid
//   s_last        in  NUM_REQ        producer end-of-burst
//   s_ready       out NUM_REQ        producer ready (only the granted bit can be set)
//   m_data        out WIDTH          data to FIFO
//   m_valid       out 1              valid to FIFO
//   m_ready       in  1              FIFO not full
//   m_last        out 1              end-of-burst from the granted producer
//   m_src         out LOG_REQ        index of the granted producer
// Optional (macro FIFO_ARB_STATS_EN):
//   beat_count    out NUM_REQ*32     per-requester wrapping count of beats moved
//   burst_trunc   out NUM_REQ        sticky: a burst ended on MAX_BURST, not s_last
// ---------------------------------------------------------------------------
module fifo_ingress_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int LOG_REQ   = 2,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int LOG_BURST = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ*WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]       s_valid,
    input  logic [NUM_REQ-1:0]       s_last,
    output logic [NUM_REQ-1:0]       s_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [LOG_REQ-1:0]       m_src
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    beat_count,
    output logic [NUM_REQ-1:0]       burst_trunc
`endif
);

    localparam logic [LOG_BURST:0] LAST_BEAT = (LOG_BURST + 1)'(MAX_BURST - 1);
    localparam logic [LOG_BURST:0] BEAT_ONE  = (LOG_BURST + 1)'(1);

    arb_state_e         state_q, state_d;
    logic [LOG_REQ-1:0] grant_q, grant_d;
    logic [LOG_REQ-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_BURST:0] beat_cnt_q, beat_cnt_d;

    logic [LOG_REQ-1:0] pick_idx;
    logic               pick_any;
    logic               sel_valid;
    logic               sel_last;
    logic               beat;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .LOG_REQ (LOG_REQ)
    ) u_pick (
        .req       (s_valid),
        .ptr       (rr_ptr_q),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    // Steer the granted producer's fields; decoded with constant slices so
    // the mux stays a plain one-hot select.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        m_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == LOG_REQ'(i)) begin
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
                m_data    = s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and outputs. A burst ends on a beat that carries s_last or
    // that is the MAX_BURST-th beat; either way the pointer moves past the
    // granted requester so it goes to the back of the queue.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_src      = grant_q;
        s_ready    = '0;
        beat       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                m_valid = sel_valid;
                m_last  = sel_last;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == LOG_REQ'(i)) begin
                        s_ready[i] = m_ready;
                    end
                end
                beat = sel_valid && m_ready;
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    if (sel_last || (beat_cnt_q == LAST_BEAT)) begin
                        rr_ptr_d = LOG_REQ'(next_rr(int'(grant_q), NUM_REQ));
                        state_d  = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] beat_count_q, beat_count_d;
    logic [NUM_REQ-1:0]    burst_trunc_q, burst_trunc_d;
    logic                  trunc_end;

    // A truncated burst is one closed by the beat limit alone; a beat that
    // carries s_last on the limit still counts as a normal end.
    always_comb begin
        beat_count_d  = beat_count_q;
        burst_trunc_d = burst_trunc_q;
        trunc_end     = beat && !sel_last && (beat_cnt_q == LAST_BEAT);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == LOG_REQ'(i)) begin
                if (beat) begin
                    beat_count_d[i*32 +: 32] = beat_count_q[i*32 +: 32] + 32'd1;
                end
                if (trunc_end) begin
                    burst_trunc_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_count_q  <= '0;
            burst_trunc_q <= '0;
        end else begin
            beat_count_q  <= beat_count_d;
            burst_trunc_q <= burst_trunc_d;
        end
    end

    assign beat_count  = beat_count_q;
    assign burst_trunc = burst_trunc_q;
`endif

endmodule

// File: tb/tb_fifo_ingress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_ingress_arbiter
// Directed bench for fifo_ingress_arbiter. Each requester is a small producer
// that advances its sequence number on every handshake; expected grant order,
// data, last flags and bubbles are hand-derived per scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_ingress_arbiter;
    import fifo_arb_pkg::*;

    localparam int WIDTH     = 72;
    localparam int NUM_REQ   = 4;
    localparam int LOG_REQ   = 2;
    localparam int MAX_BURST = 16;
    localparam int LOG_BURST = 4;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NUM_REQ*WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]       s_valid;
    logic [NUM_REQ-1:0]       s_last;
    logic [NUM_REQ-1:0]       s_ready;
    logic [WIDTH-1:0]         m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic [LOG_REQ-1:0]       m_src;
`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]    beat_count;
    logic [NUM_REQ-1:0]       burst_trunc;
`endif

    int checks   = 0;
    int failures = 0;

    // Producer model state: beats still to send, next sequence number,
    // burst length for s_last (0 = never), position inside the burst.
    int   prod_left  [NUM_REQ];
    int   prod_seq   [NUM_REQ];
    int   prod_burst [NUM_REQ];
    int   prod_pos   [NUM_REQ];
    logic hs         [NUM_REQ];
    logic ready_cfg;
    logic rstn_cfg;

    fifo_ingress_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_REQ   (NUM_REQ),
        .LOG_REQ   (LOG_REQ),
        .MAX_BURST (MAX_BURST),
        .LOG_BURST (LOG_BURST)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_src   (m_src)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_count  (beat_count),
        .burst_trunc (burst_trunc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] make_data(input int src, input int seq);
        return {8'(src), 32'hD47A_0000, 32'(seq)};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            s_valid[i] = (prod_left[i] > 0);
            s_last[i]  = (prod_left[i] > 0) && (prod_burst[i] != 0) &&
                         (prod_pos[i] == prod_burst[i] - 1);
            s_data[i*WIDTH +: WIDTH] = make_data(i, prod_seq[i]);
        end
        m_ready = ready_cfg;
        resetn  = rstn_cfg;
    endtask

    // One clock: producers advance on the previous handshake, inputs change
    // just after the rising edge, outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                prod_pos[i]  = s_last[i] ? 0 : prod_pos[i] + 1;
                prod_seq[i]  = prod_seq[i] + 1;
                prod_left[i] = prod_left[i] - 1;
            end
        end
        drive();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            hs[i] = s_valid[i] && s_ready[i];
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            prod_left[i]  = 0;
            prod_seq[i]   = 0;
            prod_burst[i] = 0;
            prod_pos[i]   = 0;
            hs[i]         = 1'b0;
        end
        ready_cfg = 1'b1;
        rstn_cfg  = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rstn_cfg = 1'b1;
        drive();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            prod_left[i] = 5; prod_seq[i] = 0; prod_burst[i] = 0; prod_pos[i] = 0; hs[i] = 1'b0;
        end
        ready_cfg = 1'b1;
        rstn_cfg  = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
        checks++;
        if (s_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_s_ready got %b want 0000", s_ready); end
        checks++;
        if (m_src !== 2'd0 || m_last !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_src_last got src=%0d last=%b want src=0 last=0", m_src, m_last);
        end
        checks++;
        if (dut.state_q !== ARB_IDLE || dut.rr_ptr_q !== 2'd0 || dut.beat_cnt_q !== 5'd0) begin
            failures++; $display("[TB] FAIL reset_regs got state=%0d rr=%0d cnt=%0d want 0 0 0", dut.state_q, dut.rr_ptr_q, dut.beat_cnt_q);
        end
    endtask

    task automatic test_single();
        apply_reset();
        prod_left[1] = 3; prod_burst[1] = 3;
        cycle();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL single_bubble got valid=%b ready=%b want 0 0000", m_valid, s_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== make_data(1, k) || m_last !== 1'(k == 2)) begin
                failures++;
                $display("[TB] FAIL single_beat%0d got valid=%b src=%0d data=%h last=%b want 1 1 %h %b",
                         k, m_valid, m_src, m_data, m_last, make_data(1, k), 1'(k == 2));
            end
            checks++;
            if (s_ready !== 4'b0010) begin failures++; $display("[TB] FAIL single_ready%0d got %b want 0010", k, s_ready); end
        end
        cycle();
        checks++;
        if (m_valid !== 1'b0 || dut.state_q !== ARB_IDLE) begin
            failures++; $display("[TB] FAIL single_end got valid=%b state=%0d want 0 IDLE", m_valid, dut.state_q);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd2) begin failures++; $display("[TB] FAIL single_rr_ptr got %0d want 2", dut.rr_ptr_q); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin prod_left[i] = 4; prod_burst[i] = 2; end
        for (int b = 0; b < 8; b++) begin
            cycle();
            checks++;
            if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL fair_bubble%0d got valid=%b want 0", b, m_valid); end
            for (int j = 0; j < 2; j++) begin
                cycle();
                checks++;
                if (m_valid !== 1'b1 || m_src !== 2'(b % 4) || m_data !== make_data(b % 4, 2 * (b / 4) + j) ||
                    m_last !== 1'(j == 1)) begin
                    failures++;
                    $display("[TB] FAIL fair_b%0d_j%0d got valid=%b src=%0d data=%h last=%b want 1 %0d %h %b",
                             b, j, m_valid, m_src, m_data, m_last, b % 4, make_data(b % 4, 2 * (b / 4) + j), 1'(j == 1));
                end
            end
        end
    endtask

    task automatic test_truncation();
        int exp_src;
        int exp_seq;
        apply_reset();
        prod_left[2] = 20; prod_burst[2] = 0;
        prod_left[3] = 2;  prod_burst[3] = 2;
        // cycle 0 bubble, 1..16 req2 seq 0..15, 17 bubble, 18..19 req3,
        // 20 bubble, 21..24 req2 seq 16..19
        for (int c = 0; c < 25; c++) begin
            cycle();
            exp_src = -1; exp_seq = 0;
            if (c >= 1 && c <= 16)  begin exp_src = 2; exp_seq = c - 1;  end
            if (c >= 18 && c <= 19) begin exp_src = 3; exp_seq = c - 18; end
            if (c >= 21)            begin exp_src = 2; exp_seq = c - 5;  end
            checks++;
            if (exp_src < 0) begin
                if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL trunc_bubble_c%0d got valid=%b want 0", c, m_valid); end
            end else if (m_valid !== 1'b1 || m_src !== 2'(exp_src) || m_data !== make_data(exp_src, exp_seq) ||
                         m_last !== 1'(c == 19)) begin
                failures++;
                $display("[TB] FAIL trunc_c%0d got valid=%b src=%0d data=%h last=%b want 1 %0d %h %b",
                         c, m_valid, m_src, m_data, m_last, exp_src, make_data(exp_src, exp_seq), 1'(c == 19));
            end
        end
        // Producer is drained; the grant is kept with nothing to send.
        cycle();
        checks++;
        if (m_valid !== 1'b0 || m_src !== 2'd2 || dut.state_q !== ARB_GRANT || dut.beat_cnt_q !== 5'd4) begin
            failures++;
            $display("[TB] FAIL trunc_hold got valid=%b src=%0d state=%0d cnt=%0d want 0 2 GRANT 4",
                     m_valid, m_src, dut.state_q, dut.beat_cnt_q);
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (burst_trunc !== 4'b0100) begin failures++; $display("[TB] FAIL stats_trunc got %b want 0100", burst_trunc); end
        checks++;
        if (beat_count[2*32 +: 32] !== 32'd20 || beat_count[3*32 +: 32] !== 32'd2) begin
            failures++; $display("[TB] FAIL stats_count got r2=%0d r3=%0d want 20 2", beat_count[2*32 +: 32], beat_count[3*32 +: 32]);
        end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        prod_left[0] = 4; prod_burst[0] = 4;
        cycle();
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_data !== make_data(0, 0)) begin
            failures++; $display("[TB] FAIL bp_first got valid=%b data=%h want 1 %h", m_valid, m_data, make_data(0, 0));
        end
        ready_cfg = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (m_valid !== 1'b1 || m_data !== make_data(0, 1) || s_ready !== 4'b0000 || dut.beat_cnt_q !== 5'd1) begin
                failures++;
                $display("[TB] FAIL bp_stall%0d got valid=%b data=%h ready=%b cnt=%0d want 1 %h 0000 1",
                         k, m_valid, m_data, s_ready, dut.beat_cnt_q, make_data(0, 1));
            end
        end
        ready_cfg = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cycle();
            checks++;
            if (m_valid !== 1'b1 || m_data !== make_data(0, k) || s_ready !== 4'b0001 || m_last !== 1'(k == 3) ||
                dut.beat_cnt_q !== 5'(k)) begin
                failures++;
                $display("[TB] FAIL bp_resume%0d got valid=%b data=%h ready=%b last=%b cnt=%0d want 1 %h 0001 %b %0d",
                         k, m_valid, m_data, s_ready, m_last, dut.beat_cnt_q, make_data(0, k), 1'(k == 3), k);
            end
        end
        cycle();
        checks++;
        if (m_valid !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin
            failures++; $display("[TB] FAIL bp_end got valid=%b rr=%0d want 0 1", m_valid, dut.rr_ptr_q);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        prod_left[2] = 1; prod_burst[2] = 1;
        cycle();
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd2 || m_last !== 1'b1) begin
            failures++; $display("[TB] FAIL wrap_setup got valid=%b src=%0d last=%b want 1 2 1", m_valid, m_src, m_last);
        end
        prod_left[0] = 1; prod_burst[0] = 1;
        prod_left[1] = 1; prod_burst[1] = 1;
        cycle();
        checks++;
        if (m_valid !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin
            failures++; $display("[TB] FAIL wrap_ptr got valid=%b rr=%0d want 0 3", m_valid, dut.rr_ptr_q);
        end
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== make_data(0, 0)) begin
            failures++; $display("[TB] FAIL wrap_first got valid=%b src=%0d data=%h want 1 0 %h", m_valid, m_src, m_data, make_data(0, 0));
        end
        cycle();
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== make_data(1, 0)) begin
            failures++; $display("[TB] FAIL wrap_second got valid=%b src=%0d data=%h want 1 1 %h", m_valid, m_src, m_data, make_data(1, 0));
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        prod_left[0] = 1; prod_burst[0] = 1;
        prod_left[1] = 4; prod_burst[1] = 4;
        cycle();
        cycle();
        cycle();
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== make_data(1, 0)) begin
            failures++; $display("[TB] FAIL rstmid_beat1 got valid=%b src=%0d data=%h want 1 1 %h", m_valid, m_src, m_data, make_data(1, 0));
        end
        rstn_cfg = 1'b0;
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_data !== make_data(1, 1)) begin
            failures++; $display("[TB] FAIL rstmid_beat2 got valid=%b data=%h want 1 %h", m_valid, m_data, make_data(1, 1));
        end
        rstn_cfg = 1'b1;
        cycle();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 4'b0000) begin
            failures++; $display("[TB] FAIL rstmid_out got valid=%b ready=%b want 0 0000", m_valid, s_ready);
        end
        checks++;
        if (dut.state_q !== ARB_IDLE || dut.rr_ptr_q !== 2'd0 || m_src !== 2'd0) begin
            failures++; $display("[TB] FAIL rstmid_regs got state=%0d rr=%0d src=%0d want IDLE 0 0", dut.state_q, dut.rr_ptr_q, m_src);
        end
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_src !== 2'd1 || m_data !== make_data(1, 2) || m_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_regrant got valid=%b src=%0d data=%h last=%b want 1 1 %h 0", m_valid, m_src, m_data, m_last, make_data(1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_truncation();
        test_backpressure();
        test_wrap();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
